regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-side sequencer for the 64-bit integer register file: collects completed results from the ALU and the load unit, arbitrates them onto the register file's single write port (`RegWrite`/`WriteReg`/`WriteData`), and tracks pending destinations in a 32-bit scoreboard. It sits between execute/memory and the register file, and it is the only block that drives the register file's write port. The issue stage reads `busy` to stall on RAW/WAW hazards.

## Interface
- `XLEN`, 64, data width; matches the register file `WriteData` width.
- `LD_DEPTH`, 2, load-result FIFO depth; power of two and at least 2.

- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  an instruction with a destination register is issued this cycle.
- `issue_rd`  in  5  destination of the issued instruction.
- `alu_valid`  in  1  an ALU result is offered.
- `alu_rd`  in  5  ALU result destination.
- `alu_data`  in  XLEN  ALU result.
- `alu_ready`  out  1  ALU result is accepted when `alu_valid && alu_ready`.
- `ld_valid`  in  1  a load result is offered.
- `ld_rd`  in  5  load destination.
- `ld_data`  in  XLEN  load result.
- `ld_ready`  out  1  load result is accepted when `ld_valid && ld_ready`.
- `RegWrite`  out  1  register file write enable (registered).
- `WriteReg`  out  5  register file write address (registered).
- `WriteData`  out  XLEN  register file write data (registered).
- `busy`  out  32  scoreboard; bit i set means a write to xi is outstanding. Bit 0 is always 0.

## Operation
- ALU path: one-entry holding register (`alu_hold`). Load path: `LD_DEPTH`-entry FIFO.
- Arbitration is evaluated each cycle from registered state only:
  - If only one source has an entry, that source is granted.
  - If both have an entry, the source not granted last time wins, using a `last_grant` bit (0 = ALU, 1 = load).
  - `last_grant` updates only on a contested grant.
- On a grant, the entry moves into the output registers at the next edge. `RegWrite` is loaded with `rd != 0`, `WriteReg` with rd, and `WriteData` with data.
- If nothing is granted, `RegWrite` goes to 0 and `WriteReg`/`WriteData` hold their values.
- Entries with rd = 0 are accepted and drained normally but never assert `RegWrite`.
- Ready signals:
  - `alu_ready = !alu_hold_valid || alu_grant`.
  - `ld_ready = (ld_count < LD_DEPTH) || ld_grant`.
  - Neither has a combinational path from any `*_valid`, `*_rd` or `*_data` input.
- Scoreboard:
  - `busy[issue_rd]` is set at the edge where `issue_valid && issue_rd != 0`.
  - `busy[WriteReg]` is cleared at the edge where `RegWrite == 1`, which is the same edge the register file commits the data.
  - If set and clear hit the same register at the same edge, set wins.
- The issue stage must not issue to a register whose `busy` bit is already set. Behaviour under that violation is undefined and is not checked.
- Results must carry a destination that was previously issued. An unissued rd is still written, and its busy bit stays 0.

## Timing
- Reset values, applied asynchronously while `reset_n` is low: `RegWrite` 0, `WriteReg` 0, `WriteData` 0, `busy` 0, `alu_hold` empty, FIFO empty (`ld_count` 0), `last_grant` 0.
- Effect of reset: `alu_ready` and `ld_ready` read 1 from the first cycle after release.
- Reset mid-operation discards all held and queued results and clears the scoreboard. No write is emitted after release.
- Latency: a result accepted at edge k is granted at the earliest at edge k+1. `RegWrite` is high during cycle k+1..k+2, the register file commits at edge k+2, and the busy bit clears at edge k+2.
- Throughput: one write per cycle in total. With a continuous ALU stream and no loads, `alu_ready` stays 1 and `RegWrite` is high every cycle.
- Contention: ALU and load alternate grants, so each gets one write every 2 cycles.
- Full FIFO with simultaneous grant: a load is accepted (`ld_ready` = 1) and the count is unchanged. FIFO pointers wrap modulo `LD_DEPTH`.
- `RegWrite` is never high for two consecutive cycles with the same entry; each entry is written exactly once.

## Test plan
- Reset: hold `reset_n` low mid-stream with a full FIFO -> all outputs 0, `busy` = 0; after release, no `RegWrite` until new input arrives.
- Single ALU write: issue x5 at edge 0; offer ALU rd=5, data=0x0000_0000_DEAD_BEEF, accepted at edge 2 -> `RegWrite`=1, `WriteReg`=5, `WriteData`=0xDEADBEEF during cycle 3..4; `busy[5]` is 1 from edge 0 until edge 4, then 0.
- x0 suppression: ALU rd=0, data=0x1234 -> accepted and drained; `RegWrite` stays 0; `busy[0]` stays 0.
- Contention: ALU and load offered every cycle (rd 1..8 alternating) -> `WriteReg` sequence load, ALU, load, ALU…; no entry lost or duplicated; `RegWrite` high every cycle.
- FIFO full: block grants by keeping `alu_hold` full with a stream that wins on alternation, fill the FIFO with 2 loads (rd 10, 11) -> `ld_ready` is 0 only in cycles where the FIFO is full and not granted; rd 10 is written before rd 11.
- Set/clear collision: re-issue x7 at the exact edge its previous write commits -> `busy[7]` remains 1 after that edge.

Source files
------------

// File: rtl/regfile_writeback.sv
// Write-side sequencer for the integer register file: arbitrates ALU and load
// results onto the single write port and tracks outstanding destinations.
module regfile_writeback #(
  parameter int XLEN     = 64,
  parameter int LD_DEPTH = 2
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            ld_ready,
  output logic            RegWrite,
  output logic [4:0]      WriteReg,
  output logic [XLEN-1:0] WriteData,
  output logic [31:0]     busy
);

  localparam int PW = $clog2(LD_DEPTH);
  localparam logic [PW:0] LD_FULL = (PW+1)'(LD_DEPTH);

  typedef enum logic {SRC_ALU = 1'b0, SRC_LD = 1'b1} src_t;

  logic            alu_hold_valid;
  logic [4:0]      alu_hold_rd;
  logic [XLEN-1:0] alu_hold_data;

  logic [4:0]      ld_rd_q   [LD_DEPTH];
  logic [XLEN-1:0] ld_data_q [LD_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     ld_count;

  src_t            last_grant;
  logic            ld_nonempty;
  logic            contested;
  logic            alu_grant;
  logic            ld_grant;
  logic            alu_push;
  logic            ld_push;
  logic [31:0]     busy_next;

  // Grants depend only on registered state, so ready never sees input valids.
  always_comb begin
    ld_nonempty = (ld_count != '0);
    contested   = alu_hold_valid && ld_nonempty;
    alu_grant   = alu_hold_valid && (!ld_nonempty || last_grant == SRC_LD);
    ld_grant    = ld_nonempty && (!alu_hold_valid || last_grant == SRC_ALU);
  end

  assign alu_ready = !alu_hold_valid || alu_grant;
  assign ld_ready  = (ld_count < LD_FULL) || ld_grant;
  assign alu_push  = alu_valid && alu_ready;
  assign ld_push   = ld_valid && ld_ready;

  // Set after clear so a re-issue at the committing edge keeps the bit high.
  always_comb begin
    busy_next = busy;
    if (RegWrite) busy_next[WriteReg] = 1'b0;
    if (issue_valid && issue_rd != '0) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (ld_push) begin
      ld_rd_q[wr_ptr]   <= ld_rd;
      ld_data_q[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_hold_valid <= 1'b0;
      alu_hold_rd    <= '0;
      alu_hold_data  <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      ld_count       <= '0;
      last_grant     <= SRC_ALU;
      RegWrite       <= 1'b0;
      WriteReg       <= '0;
      WriteData      <= '0;
      busy           <= '0;
    end else begin
      if (alu_push) begin
        alu_hold_valid <= 1'b1;
        alu_hold_rd    <= alu_rd;
        alu_hold_data  <= alu_data;
      end else if (alu_grant) begin
        alu_hold_valid <= 1'b0;
      end

      if (ld_push)  wr_ptr <= wr_ptr + 1'b1;
      if (ld_grant) rd_ptr <= rd_ptr + 1'b1;
      if (ld_push && !ld_grant)      ld_count <= ld_count + 1'b1;
      else if (!ld_push && ld_grant) ld_count <= ld_count - 1'b1;

      if (contested) last_grant <= ld_grant ? SRC_LD : SRC_ALU;

      if (alu_grant) begin
        RegWrite  <= (alu_hold_rd != '0);
        WriteReg  <= alu_hold_rd;
        WriteData <= alu_hold_data;
      end else if (ld_grant) begin
        RegWrite  <= (ld_rd_q[rd_ptr] != '0);
        WriteReg  <= ld_rd_q[rd_ptr];
        WriteData <= ld_data_q[rd_ptr];
      end else begin
        RegWrite  <= 1'b0;
      end

      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: expected writes queued at stimulus time,
// popped and compared whenever the write port fires.
module tb_regfile_writeback;

  logic        clock;
  logic        reset_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [63:0] ld_data;
  logic        ld_ready;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [63:0] WriteData;
  logic [31:0] busy;

  int tests = 0;
  int fails = 0;
  logic [68:0] exp_q[$];
  logic [68:0] mon_exp;
  logic        ldr_log [16];
  logic        rw_log  [16];

  regfile_writeback #(.XLEN(64), .LD_DEPTH(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [63:0] alu_val(input logic [4:0] rd);
    return {32'hA11A_5EED, 27'd0, rd};
  endfunction

  function automatic logic [63:0] ld_val(input logic [4:0] rd);
    return {32'hB00B_1EAD, 27'd0, rd};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Offers n ALU and n load results back to back, advancing on each handshake.
  task automatic stream(input int n, input int ncyc, input int a_base, input int l_base, input int step);
    int ai = 0;
    int li = 0;
    for (int c = 0; c < ncyc; c++) begin
      alu_valid = (ai < n);
      alu_rd    = 5'(a_base + step * ai);
      alu_data  = alu_val(alu_rd);
      ld_valid  = (li < n);
      ld_rd     = 5'(l_base + step * li);
      ld_data   = ld_val(ld_rd);
      ldr_log[c] = ld_ready;
      rw_log[c]  = RegWrite;
      if (alu_valid && alu_ready) ai++;
      if (ld_valid && ld_ready) li++;
      tick();
    end
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  always @(negedge clock) begin
    if (reset_n && RegWrite) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_write: observed rd=%0d data=%0h expected no write", WriteReg, WriteData);
      end
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        tests++;
        assert ({WriteReg, WriteData} === mon_exp) else begin
          fails++;
          $error("FAIL write_order: observed rd=%0d data=%0h expected rd=%0d data=%0h",
                 WriteReg, WriteData, mon_exp[68:64], mon_exp[63:0]);
        end
      end
    end
  end

  initial begin
    int hi;
    reset_n = 1'b0; issue_valid = 1'b0; issue_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    repeat (2) tick();
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_writereg", 64'(WriteReg), 64'd0);
    chk("rst_writedata", WriteData, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    chk("rel_alu_ready", 64'(alu_ready), 64'd1);
    chk("rel_ld_ready", 64'(ld_ready), 64'd1);
    tick();

    // single ALU write to x5
    issue_valid = 1'b1; issue_rd = 5'd5; tick();
    issue_valid = 1'b0;
    chk("busy5_set", 64'(busy[5]), 64'd1);
    tick();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h0000_0000_DEAD_BEEF;
    exp_q.push_back({5'd5, 64'h0000_0000_DEAD_BEEF});
    tick();
    alu_valid = 1'b0;
    chk("single_no_write_yet", 64'(RegWrite), 64'd0);
    tick();
    chk("single_regwrite", 64'(RegWrite), 64'd1);
    chk("single_writereg", 64'(WriteReg), 64'd5);
    chk("single_writedata", WriteData, 64'h0000_0000_DEAD_BEEF);
    chk("busy5_held", 64'(busy[5]), 64'd1);
    tick();
    chk("busy5_clear", 64'(busy[5]), 64'd0);
    chk("single_regwrite_drop", 64'(RegWrite), 64'd0);

    // x0 destination drains without a write
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h1234;
    tick();
    alu_valid = 1'b0;
    tick();
    chk("x0_no_regwrite", 64'(RegWrite), 64'd0);
    chk("x0_drained_data", WriteData, 64'h1234);
    chk("x0_busy", 64'(busy), 64'd0);
    tick();
    chk("x0_alu_ready", 64'(alu_ready), 64'd1);

    // contention: loads take odd rds, ALU even; load wins first
    for (int i = 1; i <= 8; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i); tick();
    end
    issue_valid = 1'b0;
    chk("cont_busy_set", 64'(busy), 64'h1FE);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({5'(2*i+1), ld_val(5'(2*i+1))});
      exp_q.push_back({5'(2*i+2), alu_val(5'(2*i+2))});
    end
    stream(4, 12, 2, 1, 2);
    chk("cont_full_granted_ready", 64'(ldr_log[3]), 64'd1);
    chk("cont_full_blocked_ready", 64'(ldr_log[4]), 64'd0);
    hi = 0;
    for (int c = 2; c <= 9; c++) hi += int'(rw_log[c]);
    chk("cont_write_every_cycle", 64'(hi), 64'd8);
    chk("cont_drained", 64'(exp_q.size()), 64'd0);
    chk("cont_busy_clear", 64'(busy), 64'd0);

    // FIFO full behind an ALU stream, then reset mid-stream
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(20 + i); tick();
      issue_rd = 5'(10 + i); tick();
    end
    issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({5'(20+i), alu_val(5'(20+i))});
      exp_q.push_back({5'(10+i), ld_val(5'(10+i))});
    end
    stream(4, 5, 20, 10, 1);
    chk("fifo_full_granted_ready", 64'(ldr_log[2]), 64'd1);
    chk("fifo_full_blocked_ready", 64'(ldr_log[3]), 64'd0);
    chk("fifo_busy_pre_reset", 64'(busy), 64'h00C0_3800);
    reset_n = 1'b0;
    #2;
    chk("mid_rst_regwrite", 64'(RegWrite), 64'd0);
    chk("mid_rst_writereg", 64'(WriteReg), 64'd0);
    chk("mid_rst_writedata", WriteData, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("writes_before_reset", 64'(exp_q.size()), 64'd5);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    chk("post_rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("post_rst_ld_ready", 64'(ld_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_quiet", 64'(RegWrite), 64'd0);
    end

    // re-issue x7 on the edge its write commits
    issue_valid = 1'b1; issue_rd = 5'd7; tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h7777_0000_0000_0001;
    exp_q.push_back({5'd7, 64'h7777_0000_0000_0001});
    tick();
    alu_valid = 1'b0;
    tick();
    chk("coll_write_cycle", 64'(RegWrite), 64'd1);
    issue_valid = 1'b1; issue_rd = 5'd7; tick();
    issue_valid = 1'b0;
    chk("coll_busy7_kept", 64'(busy[7]), 64'd1);
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h7777_0000_0000_0002;
    exp_q.push_back({5'd7, 64'h7777_0000_0000_0002});
    tick();
    alu_valid = 1'b0;
    tick();
    tick();
    chk("coll_busy_final", 64'(busy), 64'd0);

    // unissued destination is written but never marked busy
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = alu_val(5'd3);
    exp_q.push_back({5'd3, alu_val(5'd3)});
    tick();
    alu_valid = 1'b0;
    tick();
    chk("unissued_writereg", 64'(WriteReg), 64'd3);
    chk("unissued_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
